// File: rtl/soc_it_master_pkg.sv
// Shared types and constants for the SoC-IT master data front end.
package soc_it_master_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_TAG_W  = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  // Width of a channel index; a single channel pair still needs one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/soc_it_skid_buf.sv
// Two-entry valid/ready skid buffer: 1 cycle input-to-output latency, 1 beat/cycle.
// Registered in_rdy drops only when both entries are full; head entry drives the output directly.
module soc_it_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_vld,
  output logic         o_in_rdy,
  input  logic [W-1:0] i_in_dat,
  output logic         o_out_vld,
  input  logic         i_out_rdy,
  output logic [W-1:0] o_out_dat
);

  logic [1:0]   r_cnt;
  logic         r_in_rdy;
  logic [W-1:0] r_dat0;
  logic [W-1:0] r_dat1;

  logic         w_push;
  logic         w_pop;
  logic         w_wr0;
  logic         w_wr1;
  logic [1:0]   w_cnt_nxt;

  assign w_push    = i_in_vld & r_in_rdy;
  assign w_pop     = i_out_rdy & (r_cnt != 2'd0);
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // New beat lands in the head slot if the buffer is empty or the head leaves this cycle.
  assign w_wr0     = w_push & ((r_cnt == 2'd0) | ((r_cnt == 2'd1) & w_pop));
  assign w_wr1     = w_push & (r_cnt == 2'd1) & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 2'd0;
      r_in_rdy <= 1'b0;
      r_dat0   <= '0;
      r_dat1   <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_in_rdy <= (w_cnt_nxt != 2'd2);
      if (w_wr0) begin
        r_dat0 <= i_in_dat;
      end else if (w_pop && (r_cnt == 2'd2)) begin
        r_dat0 <= r_dat1;
      end
      if (w_wr1) begin
        r_dat1 <= i_in_dat;
      end
    end
  end

  assign o_in_rdy  = r_in_rdy;
  assign o_out_vld = (r_cnt != 2'd0);
  assign o_out_dat = r_dat0;

endmodule

// File: rtl/soc_it_master_data_arb.sv
// Round-robin burst arbiter onto master_datain plus tag-routed master_dataout demux, both skid-buffered.
// One cycle latency each way; channels see dst_rdy fall once the relevant skid fills.
module soc_it_master_data_arb
  import soc_it_master_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_datain_src_rdy,
  output logic [NUM_CH-1:0]        ch_datain_dst_rdy,
  input  logic [NUM_CH-1:0]        ch_datain_last,
  input  logic [NUM_CH*DATA_W-1:0] ch_datain,
  output logic                     master_datain_src_rdy,
  input  logic                     master_datain_dst_rdy,
  output logic [TAG_W-1:0]         master_datain_tag,
  output logic [DATA_W-1:0]        master_datain,
  input  logic                     master_dataout_src_rdy,
  output logic                     master_dataout_dst_rdy,
  input  logic [TAG_W-1:0]         master_dataout_tag,
  input  logic [DATA_W-1:0]        master_dataout,
  output logic [NUM_CH-1:0]        ch_dataout_src_rdy,
  input  logic [NUM_CH-1:0]        ch_dataout_dst_rdy,
  output logic [DATA_W-1:0]        ch_dataout,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     drop_err
);

  localparam int IDX_W = ch_idx_w(NUM_CH);
  localparam int BUF_W = DATA_W + TAG_W;
  localparam logic [TAG_W:0] NUM_CH_T = (TAG_W+1)'(NUM_CH);

  arb_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_rr, w_rr_nxt;
  logic [IDX_W-1:0]  r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]  w_sel_hi, w_sel_lo, w_gnt, w_gnt_inc;
  logic              w_any_hi, w_any_lo;
  logic              w_act, w_req, w_last, w_acc, w_in_rdy;
  logic [DATA_W-1:0] w_dat;
  logic [BUF_W-1:0]  w_in_q;

  logic              w_ret_vld, w_ret_hit, w_ret_pop, w_drop;
  logic [BUF_W-1:0]  w_ret_q;
  logic [TAG_W-1:0]  w_ret_tag;
  logic [NUM_CH-1:0] w_ret_sel;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_drop_err;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin : rr_search
    w_any_hi = 1'b0;
    w_any_lo = 1'b0;
    w_sel_hi = '0;
    w_sel_lo = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_datain_src_rdy[c]) begin
        w_any_lo = 1'b1;
        w_sel_lo = IDX_W'(c);
        if (IDX_W'(c) >= r_rr) begin
          w_any_hi = 1'b1;
          w_sel_hi = IDX_W'(c);
        end
      end
    end
  end

  always_comb begin : gnt_mux
    w_act             = (r_state == ARB_BURST) | w_any_lo;
    w_gnt             = (r_state == ARB_BURST) ? r_gnt : (w_any_hi ? w_sel_hi : w_sel_lo);
    w_req             = 1'b0;
    w_last            = 1'b0;
    w_dat             = '0;
    ch_datain_dst_rdy = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (IDX_W'(c) == w_gnt) begin
        w_req                = ch_datain_src_rdy[c];
        w_last               = ch_datain_last[c];
        w_dat                = ch_datain[c*DATA_W +: DATA_W];
        ch_datain_dst_rdy[c] = w_act & w_in_rdy;
      end
    end
    w_acc     = w_act & w_req & w_in_rdy;
    w_gnt_inc = (w_gnt == IDX_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
  end

  always_comb begin : arb_next
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_acc) begin
          if (w_last) begin
            w_rr_nxt = w_gnt_inc;
          end else begin
            w_state_nxt = ARB_BURST;
            w_gnt_nxt   = w_gnt;
          end
        end
      end
      ARB_BURST: begin
        if (w_acc && w_last) begin
          w_state_nxt = ARB_IDLE;
          w_rr_nxt    = w_gnt_inc;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_rr    <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  soc_it_skid_buf #(.W(BUF_W)) u_datain_skid (
    .clk       (clk),
    .rst       (rst),
    .i_in_vld  (w_act & w_req),
    .o_in_rdy  (w_in_rdy),
    .i_in_dat  ({TAG_W'(w_gnt), w_dat}),
    .o_out_vld (master_datain_src_rdy),
    .i_out_rdy (master_datain_dst_rdy),
    .o_out_dat (w_in_q)
  );

  assign master_datain_tag = w_in_q[BUF_W-1 -: TAG_W];
  assign master_datain     = w_in_q[DATA_W-1:0];

  soc_it_skid_buf #(.W(BUF_W)) u_dataout_skid (
    .clk       (clk),
    .rst       (rst),
    .i_in_vld  (master_dataout_src_rdy),
    .o_in_rdy  (master_dataout_dst_rdy),
    .i_in_dat  ({master_dataout_tag, master_dataout}),
    .o_out_vld (w_ret_vld),
    .i_out_rdy (w_ret_pop | w_drop),
    .o_out_dat (w_ret_q)
  );

  assign w_ret_tag = w_ret_q[BUF_W-1 -: TAG_W];

  // Unroutable tags are discarded as soon as they reach the head, so they never block the path.
  always_comb begin : ret_demux
    w_ret_hit = ({1'b0, w_ret_tag} < NUM_CH_T);
    w_ret_sel = '0;
    w_ret_pop = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_ret_sel[c] = w_ret_vld & w_ret_hit & (w_ret_tag == TAG_W'(c));
      w_ret_pop    = w_ret_pop | (w_ret_sel[c] & ch_dataout_dst_rdy[c]);
    end
    w_drop = w_ret_vld & ~w_ret_hit;
  end

  assign ch_dataout_src_rdy = w_ret_sel;
  assign ch_dataout         = w_ret_q[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
      r_drop_err <= 1'b0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
      if (~&r_drop_cnt) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign drop_err = r_drop_err;

endmodule

// File: tb/tb_soc_it_master_data_arb.sv
// Scoreboard bench for soc_it_master_data_arb: directed channel traffic, queued expectations, negedge monitor.
module tb_soc_it_master_data_arb;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_datain_src_rdy, ch_datain_dst_rdy, ch_datain_last;
  logic [NCH*DW-1:0] ch_datain;
  logic              master_datain_src_rdy, master_datain_dst_rdy;
  logic [TW-1:0]     master_datain_tag;
  logic [DW-1:0]     master_datain;
  logic              master_dataout_src_rdy, master_dataout_dst_rdy;
  logic [TW-1:0]     master_dataout_tag;
  logic [DW-1:0]     master_dataout;
  logic [NCH-1:0]    ch_dataout_src_rdy, ch_dataout_dst_rdy;
  logic [DW-1:0]     ch_dataout;
  logic [CW-1:0]     drop_cnt;
  logic              drop_err;

  // Small-counter instance used only for saturation.
  logic [NCH-1:0]    s_ch_src, s_ch_dst, s_ch_last, s_chout_src, s_chout_dst;
  logic [NCH*8-1:0]  s_ch_dat;
  logic              s_min_src, s_min_dst, s_mout_src, s_mout_dst, s_drop_err;
  logic [TW-1:0]     s_min_tag, s_mout_tag;
  logic [7:0]        s_min_dat, s_mout_dat, s_chout_dat;
  logic [1:0]        s_drop_cnt;

  soc_it_master_data_arb #(.NUM_CH(NCH), .DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ch_datain_src_rdy(ch_datain_src_rdy), .ch_datain_dst_rdy(ch_datain_dst_rdy),
    .ch_datain_last(ch_datain_last), .ch_datain(ch_datain),
    .master_datain_src_rdy(master_datain_src_rdy), .master_datain_dst_rdy(master_datain_dst_rdy),
    .master_datain_tag(master_datain_tag), .master_datain(master_datain),
    .master_dataout_src_rdy(master_dataout_src_rdy), .master_dataout_dst_rdy(master_dataout_dst_rdy),
    .master_dataout_tag(master_dataout_tag), .master_dataout(master_dataout),
    .ch_dataout_src_rdy(ch_dataout_src_rdy), .ch_dataout_dst_rdy(ch_dataout_dst_rdy),
    .ch_dataout(ch_dataout), .drop_cnt(drop_cnt), .drop_err(drop_err)
  );

  soc_it_master_data_arb #(.NUM_CH(NCH), .DATA_W(8), .TAG_W(TW), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .ch_datain_src_rdy(s_ch_src), .ch_datain_dst_rdy(s_ch_dst),
    .ch_datain_last(s_ch_last), .ch_datain(s_ch_dat),
    .master_datain_src_rdy(s_min_src), .master_datain_dst_rdy(s_min_dst),
    .master_datain_tag(s_min_tag), .master_datain(s_min_dat),
    .master_dataout_src_rdy(s_mout_src), .master_dataout_dst_rdy(s_mout_dst),
    .master_dataout_tag(s_mout_tag), .master_dataout(s_mout_dat),
    .ch_dataout_src_rdy(s_chout_src), .ch_dataout_dst_rdy(s_chout_dst),
    .ch_dataout(s_chout_dat), .drop_cnt(s_drop_cnt), .drop_err(s_drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct { int ch; logic [DW-1:0] dat; logic last; } tx_t;
  typedef struct { int ch; logic [DW-1:0] dat; } exp_t;

  tx_t  tx_q[$];
  exp_t exp_in[$];
  exp_t exp_out[$];
  int   in_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic q_tx(input int c, input logic [DW-1:0] d, input logic l);
    tx_t t;
    t.ch = c; t.dat = d; t.last = l;
    tx_q.push_back(t);
  endtask

  task automatic q_exp_in(input int c, input logic [DW-1:0] d);
    exp_t e;
    e.ch = c; e.dat = d;
    exp_in.push_back(e);
  endtask

  task automatic q_exp_out(input int c, input logic [DW-1:0] d);
    exp_t e;
    e.ch = c; e.dat = d;
    exp_out.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_in.size() + exp_out.size() + tx_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_in.size() + exp_out.size() + tx_q.size()), 64'd0);
  endtask

  task automatic send_out(input logic [TW-1:0] t, input logic [DW-1:0] d);
    int n = 0;
    master_dataout_src_rdy = 1'b1;
    master_dataout_tag     = t;
    master_dataout         = d;
    do begin
      @(negedge clk);
      n++;
    end while (!master_dataout_dst_rdy && n < 50);
    chk("dataout_accept", 64'(master_dataout_dst_rdy), 64'd1);
    @(posedge clk); #1;
    master_dataout_src_rdy = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({ch_datain_dst_rdy, master_datain_src_rdy, master_dataout_dst_rdy,
                            ch_dataout_src_rdy, master_datain_tag}), 64'd0);
    chk({tag, "_data"}, {master_datain, ch_dataout}, 64'd0);
    chk({tag, "_drop"}, 64'({drop_err, drop_cnt}), 64'd0);
  endtask

  // Channel driver: each channel presents its oldest queued beat and holds it until accepted.
  initial begin
    logic [NCH-1:0] acc;
    bit found;
    ch_datain_src_rdy = '0;
    ch_datain_last    = '0;
    ch_datain         = '0;
    forever begin
      @(negedge clk);
      acc = ch_datain_src_rdy & ch_datain_dst_rdy;
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (acc[c]) begin
          for (int k = 0; k < tx_q.size(); k++) begin
            if (tx_q[k].ch == c) begin
              tx_q.delete(k);
              break;
            end
          end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        found = 1'b0;
        ch_datain_src_rdy[c] = 1'b0;
        ch_datain_last[c]    = 1'b0;
        for (int k = 0; k < tx_q.size(); k++) begin
          if (!found && tx_q[k].ch == c) begin
            found = 1'b1;
            ch_datain_src_rdy[c]     = 1'b1;
            ch_datain_last[c]        = tx_q[k].last;
            ch_datain[c*DW +: DW]    = tx_q[k].dat;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a beat transfers on either output side.
  initial begin
    exp_t e;
    int   hit;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("dst_onehot0", 64'($onehot0(ch_datain_dst_rdy)), 64'd1);
        chk("chout_onehot0", 64'($onehot0(ch_dataout_src_rdy)), 64'd1);
        if (master_datain_src_rdy && master_datain_dst_rdy) begin
          in_cyc.push_back(cyc);
          checks++;
          if (exp_in.size() == 0) begin
            errors++;
            $display("FAIL datain_unexpected: got tag %0d data %0h, expected no beat",
                     master_datain_tag, master_datain);
          end else begin
            checks--;
            e = exp_in.pop_front();
            chk("datain_tag", 64'(master_datain_tag), 64'(e.ch));
            chk("datain_data", 64'(master_datain), 64'(e.dat));
          end
        end
        if (|(ch_dataout_src_rdy & ch_dataout_dst_rdy)) begin
          hit = 0;
          for (int c = 0; c < NCH; c++) if (ch_dataout_src_rdy[c]) hit = c;
          checks++;
          if (exp_out.size() == 0) begin
            errors++;
            $display("FAIL dataout_unexpected: got ch %0d data %0h, expected no beat", hit, ch_dataout);
          end else begin
            checks--;
            e = exp_out.pop_front();
            chk("dataout_ch", 64'(hit), 64'(e.ch));
            chk("dataout_data", 64'(ch_dataout), 64'(e.dat));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst                    = 1'b0;
    master_datain_dst_rdy  = 1'b1;
    master_dataout_src_rdy = 1'b0;
    master_dataout_tag     = '0;
    master_dataout         = '0;
    ch_dataout_dst_rdy     = '1;
    s_ch_src = '0; s_ch_last = '0; s_ch_dat = '0; s_min_dst = 1'b1;
    s_mout_src = 1'b0; s_mout_tag = 4'd7; s_mout_dat = 8'h5A; s_chout_dst = '1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_init");
    chk("rst_init_s_drop", 64'({s_drop_err, s_drop_cnt}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Mid-burst reset on ch1, then ch0/ch1/ch3 singles must restart from pointer 0.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      q_tx(1, DW'(32'hB0 + i), i == 3);
      q_exp_in(1, DW'(32'hB0 + i));
    end
    n = 0;
    while (exp_in.size() > 2 && n < 50) begin @(negedge clk); n++; end
    chk("t1_burst_started", 64'(exp_in.size() <= 2), 64'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_reset_outputs("t1_async_rst");
    tx_q.delete();
    exp_in.delete();
    exp_out.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q_tx(1, 32'hC1, 1'b1); q_tx(0, 32'hC0, 1'b1); q_tx(3, 32'hC3, 1'b1);
    q_exp_in(0, 32'hC0); q_exp_in(1, 32'hC1); q_exp_in(3, 32'hC3);
    wait_drain("t1_drain", 50);

    // Round-robin over all single-beat requesters, back to back.
    @(posedge clk); #1;
    in_cyc.delete();
    q_tx(0, 32'h20, 1'b1); q_tx(0, 32'h24, 1'b1); q_tx(1, 32'h21, 1'b1);
    q_tx(2, 32'h22, 1'b1); q_tx(3, 32'h23, 1'b1);
    q_exp_in(0, 32'h20); q_exp_in(1, 32'h21); q_exp_in(2, 32'h22);
    q_exp_in(3, 32'h23); q_exp_in(0, 32'h24);
    wait_drain("t2_drain", 50);
    chk("t2_beats", 64'(in_cyc.size()), 64'd5);
    if (in_cyc.size() == 5) chk("t2_consecutive", 64'(in_cyc[4] - in_cyc[0]), 64'd4);

    // Burst lock: ch2 holds the grant for four beats while ch0 waits.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      q_tx(2, DW'(32'h30 + i), i == 3);
      q_exp_in(2, DW'(32'h30 + i));
    end
    q_tx(0, 32'h40, 1'b1);
    q_exp_in(0, 32'h40);
    n = 0;
    while (tx_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
      if (ch_datain_src_rdy[2]) chk("t3_ch0_blocked", 64'(ch_datain_dst_rdy[0]), 64'd0);
    end
    wait_drain("t3_drain", 50);

    // Master backpressure: ch1 gets exactly two beats into the skid, then stalls.
    @(posedge clk); #1;
    master_datain_dst_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q_tx(1, DW'(32'hA0 + i), i == 7);
      q_exp_in(1, DW'(32'hA0 + i));
    end
    n = 0;
    while (!ch_datain_src_rdy[1] && n < 20) begin @(negedge clk); n++; end
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (ch_datain_src_rdy[1] && ch_datain_dst_rdy[1]) n++;
    end
    chk("t4_stall_accepts", 64'(n), 64'd2);
    chk("t4_ch1_dst_low", 64'(ch_datain_dst_rdy[1]), 64'd0);
    chk("t4_master_vld_held", 64'(master_datain_src_rdy), 64'd1);
    chk("t4_head_data", 64'(master_datain), 64'hA0);
    @(posedge clk); #1;
    master_datain_dst_rdy = 1'b1;
    wait_drain("t4_drain", 80);

    // Dataout routing with ch0 held not-ready.
    @(posedge clk); #1;
    ch_dataout_dst_rdy = 4'b1110;
    q_exp_out(3, 32'h11); q_exp_out(0, 32'h22); q_exp_out(1, 32'h33);
    send_out(4'd3, 32'h11);
    send_out(4'd0, 32'h22);
    send_out(4'd1, 32'h33);
    repeat (2) @(negedge clk);
    chk("t5_ch0_waiting", 64'(ch_dataout_src_rdy), 64'b0001);
    chk("t5_ch0_data", 64'(ch_dataout), 64'h22);
    chk("t5_skid_full", 64'(master_dataout_dst_rdy), 64'd0);
    @(posedge clk); #1;
    ch_dataout_dst_rdy = 4'b1111;
    wait_drain("t5_drain", 50);

    // Out-of-range tag is dropped and counted.
    @(posedge clk); #1;
    send_out(4'd7, 32'h77);
    @(negedge clk);
    chk("t6_no_route", 64'(ch_dataout_src_rdy), 64'd0);
    repeat (2) @(negedge clk);
    chk("t6_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t6_drop_err", 64'(drop_err), 64'd1);

    // Saturation on the 2-bit counter instance: one drop, then six more.
    @(posedge clk); #1;
    s_mout_src = 1'b1;
    @(posedge clk); #1;
    s_mout_src = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_s_cnt_one", 64'(s_drop_cnt), 64'd1);
    @(posedge clk); #1;
    s_mout_src = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    s_mout_src = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_s_cnt_sat", 64'(s_drop_cnt), 64'd3);
    chk("t6_s_err", 64'(s_drop_err), 64'd1);
    chk("t6_drop_cnt_final", 64'(drop_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
